// File: rtl/uart_pkg.sv
// Shared types and constants for the UART command-frame parser.
package uart_pkg;

   // Parser states, in frame order
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SYNC,
      ST_LEN,
      ST_CMD,
      ST_PAYLOAD,
      ST_CHK,
      ST_EMIT
   } state_t;

   // Error codes reported on err_code
   localparam logic [1:0] ERR_OVR = 2'd0;
   localparam logic [1:0] ERR_LEN = 2'd1;
   localparam logic [1:0] ERR_CHK = 2'd2;
   localparam logic [1:0] ERR_TMO = 2'd3;

   // Default sync bytes
   localparam logic [7:0] HDR0_DEF = 8'h55;
   localparam logic [7:0] HDR1_DEF = 8'hAA;

   // Nominal bit period and the 20-bit-time inter-byte timeout derived from it
   localparam int CLK_PER_BIT = 5208;
   localparam int TIMEOUT_DEF = 20 * CLK_PER_BIT;

   // A LEN byte is legal when it is 1..max_len
   function automatic logic len_ok(input logic [7:0] b, input int max_len);
      return (b != 8'd0) && (int'(b) <= max_len);
   endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload register file: one write port, one registered read port.
module uart_frame_buf #(
   parameter int DEPTH = 16,
   parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
)(
   input  logic          sys_clk,
   input  logic          sys_rst_n,
   input  logic          i_wr_en,
   input  logic [AW-1:0] i_wr_addr,
   input  logic [7:0]    i_wr_data,
   input  logic          i_rd_en,
   input  logic [AW-1:0] i_rd_addr,
   output logic [7:0]    o_rd_data
);

   logic [DEPTH-1:0][7:0] r_mem;
   logic [7:0]            r_rd_data;

   // Storage needs no reset: contents are only read after being written
   always_ff @(posedge sys_clk) begin
      if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
   end

   // Read register doubles as the payload output, so it resets to 0
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n)   r_rd_data <= 8'h00;
      else if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
   end

   assign o_rd_data = r_rd_data;

endmodule

// File: rtl/uart_frame_parser.sv
// Command-frame parser: HDR0 HDR1 LEN CMD payload CHK, XOR checksum,
// inter-byte timeout, payload released only after a good checksum.
module uart_frame_parser
   import uart_pkg::*;
#(
   parameter int         MAX_LEN      = 16,
   parameter int         TIMEOUT_CLKS = TIMEOUT_DEF,
   parameter logic [7:0] HDR0         = HDR0_DEF,
   parameter logic [7:0] HDR1         = HDR1_DEF
)(
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic [7:0] in_data,
   input  logic       in_flag,
   output logic [7:0] out_cmd,
   output logic [7:0] pld_data,
   output logic       pld_valid,
   output logic       pld_last,
   output logic       frame_ok,
   output logic       err_flag,
   output logic [1:0] err_code
);

   localparam int LW = $clog2(MAX_LEN + 1);
   localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int TW = $clog2(TIMEOUT_CLKS);

   state_t        r_state;
   logic [LW-1:0] r_len;
   logic [LW-1:0] r_idx;
   logic [7:0]    r_chk;
   logic [7:0]    r_cmd_tmp;
   logic [TW-1:0] r_tmo;
   logic [7:0]    r_out_cmd;
   logic          r_pld_valid;
   logic          r_pld_last;
   logic          r_frame_ok;
   logic          r_err_flag;
   logic [1:0]    r_err_code;

   logic          w_tmo_run;
   logic          w_tmo_exp;
   logic          w_idx_last;
   logic          w_idx_next_last;
   logic          w_chk_good;
   logic          w_wr_en;
   logic          w_rd_en;
   logic [AW-1:0] w_rd_addr;
   logic [7:0]    w_rd_data;

   assign w_tmo_run       = r_state inside {ST_SYNC, ST_LEN, ST_CMD, ST_PAYLOAD, ST_CHK};
   assign w_tmo_exp       = (r_tmo == TW'(TIMEOUT_CLKS - 1));
   assign w_idx_last      = (r_idx + LW'(1) == r_len);
   assign w_idx_next_last = (r_idx + LW'(2) == r_len);
   assign w_chk_good      = (r_state == ST_CHK) && in_flag && (in_data == r_chk);

   // Buffer control: write during PAYLOAD; read byte 0 on the good CHK strobe,
   // then pre-fetch idx+1 each EMIT cycle so pld_data lines up with pld_valid
   assign w_wr_en   = (r_state == ST_PAYLOAD) && in_flag;
   assign w_rd_en   = w_chk_good || ((r_state == ST_EMIT) && !w_idx_last);
   assign w_rd_addr = (r_state == ST_CHK) ? '0 : AW'(r_idx + LW'(1));

   uart_frame_buf #(
      .DEPTH (MAX_LEN),
      .AW    (AW)
   ) u_buf (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .i_wr_en   (w_wr_en),
      .i_wr_addr (AW'(r_idx)),
      .i_wr_data (in_data),
      .i_rd_en   (w_rd_en),
      .i_rd_addr (w_rd_addr),
      .o_rd_data (w_rd_data)
   );

   // Inter-byte timeout: counts only while a frame is being received
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n)                 r_tmo <= '0;
      else if (in_flag || !w_tmo_run) r_tmo <= '0;
      else                            r_tmo <= r_tmo + TW'(1);
   end

   // Frame FSM with registered outputs; a strobe in the expiry cycle wins
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state     <= ST_IDLE;
         r_len       <= '0;
         r_idx       <= '0;
         r_chk       <= 8'h00;
         r_cmd_tmp   <= 8'h00;
         r_out_cmd   <= 8'h00;
         r_pld_valid <= 1'b0;
         r_pld_last  <= 1'b0;
         r_frame_ok  <= 1'b0;
         r_err_flag  <= 1'b0;
         r_err_code  <= ERR_OVR;
      end else begin
         r_err_flag <= 1'b0;
         r_frame_ok <= 1'b0;
         if (w_tmo_run && !in_flag && w_tmo_exp) begin
            r_state    <= ST_IDLE;
            r_err_flag <= 1'b1;
            r_err_code <= ERR_TMO;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (in_flag && in_data == HDR0) r_state <= ST_SYNC;
               end
               ST_SYNC: begin
                  if (in_flag) begin
                     if (in_data == HDR1)      r_state <= ST_LEN;
                     else if (in_data != HDR0) r_state <= ST_IDLE;
                  end
               end
               ST_LEN: begin
                  if (in_flag) begin
                     if (len_ok(in_data, MAX_LEN)) begin
                        r_len   <= LW'(in_data);
                        r_chk   <= in_data;
                        r_state <= ST_CMD;
                     end else begin
                        r_err_flag <= 1'b1;
                        r_err_code <= ERR_LEN;
                        r_state    <= ST_IDLE;
                     end
                  end
               end
               ST_CMD: begin
                  if (in_flag) begin
                     r_cmd_tmp <= in_data;
                     r_chk     <= r_chk ^ in_data;
                     r_idx     <= '0;
                     r_state   <= ST_PAYLOAD;
                  end
               end
               ST_PAYLOAD: begin
                  if (in_flag) begin
                     r_chk <= r_chk ^ in_data;
                     r_idx <= r_idx + LW'(1);
                     if (w_idx_last) r_state <= ST_CHK;
                  end
               end
               ST_CHK: begin
                  if (in_flag) begin
                     if (w_chk_good) begin
                        r_idx       <= '0;
                        r_out_cmd   <= r_cmd_tmp;
                        r_pld_valid <= 1'b1;
                        r_pld_last  <= (r_len == LW'(1));
                        r_frame_ok  <= (r_len == LW'(1));
                        r_state     <= ST_EMIT;
                     end else begin
                        r_err_flag <= 1'b1;
                        r_err_code <= ERR_CHK;
                        r_state    <= ST_IDLE;
                     end
                  end
               end
               ST_EMIT: begin
                  // A byte arriving here is dropped; emission carries on
                  if (in_flag) begin
                     r_err_flag <= 1'b1;
                     r_err_code <= ERR_OVR;
                  end
                  if (w_idx_last) begin
                     r_pld_valid <= 1'b0;
                     r_pld_last  <= 1'b0;
                     r_state     <= ST_IDLE;
                  end else begin
                     r_idx      <= r_idx + LW'(1);
                     r_pld_last <= w_idx_next_last;
                     r_frame_ok <= w_idx_next_last;
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   assign out_cmd   = r_out_cmd;
   assign pld_data  = w_rd_data;
   assign pld_valid = r_pld_valid;
   assign pld_last  = r_pld_last;
   assign frame_ok  = r_frame_ok;
   assign err_flag  = r_err_flag;
   assign err_code  = r_err_code;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed and randomized frame stimulus against a frame-level expectation.
module tb_uart_frame_parser;

   localparam int MAX_LEN = 16;
   localparam int T       = 64;

   logic       sys_clk   = 1'b0;
   logic       sys_rst_n = 1'b0;
   logic [7:0] in_data   = 8'h00;
   logic       in_flag   = 1'b0;
   logic [7:0] out_cmd;
   logic [7:0] pld_data;
   logic       pld_valid;
   logic       pld_last;
   logic       frame_ok;
   logic       err_flag;
   logic [1:0] err_code;

   uart_frame_parser #(
      .MAX_LEN      (MAX_LEN),
      .TIMEOUT_CLKS (T),
      .HDR0         (8'h55),
      .HDR1         (8'hAA)
   ) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .in_data   (in_data),
      .in_flag   (in_flag),
      .out_cmd   (out_cmd),
      .pld_data  (pld_data),
      .pld_valid (pld_valid),
      .pld_last  (pld_last),
      .frame_ok  (frame_ok),
      .err_flag  (err_flag),
      .err_code  (err_code)
   );

   always #5 sys_clk = ~sys_clk;

   int cyc = 0;
   always @(posedge sys_clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   // Observed output history
   logic [7:0] q_pld[$];
   bit         q_last[$];
   int         q_pcyc[$];
   logic [7:0] q_cmd[$];
   logic [1:0] q_err[$];
   int         q_ecyc[$];
   int         n_fok   = 0;
   int         mon_bad = 0;

   always @(negedge sys_clk) begin
      if (sys_rst_n) begin
         if (pld_valid) begin
            q_pld.push_back(pld_data);
            q_last.push_back(pld_last);
            q_pcyc.push_back(cyc);
            q_cmd.push_back(out_cmd);
         end
         if (frame_ok) n_fok++;
         if ((frame_ok !== pld_last) || (pld_last && !pld_valid)) mon_bad++;
         if (err_flag) begin
            q_err.push_back(err_code);
            q_ecyc.push_back(cyc);
         end
      end
   end

   // Stimulus state and expectations
   logic [7:0] tx[$];
   logic [7:0] pay[$];
   logic [7:0] exp_pld[$];
   int         last_s;
   int         fok_base = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge sys_clk);
   endtask

   task automatic strobe(input logic [7:0] b);
      in_flag = 1'b1;
      in_data = b;
      last_s  = cyc;
      @(negedge sys_clk);
      in_flag = 1'b0;
   endtask

   task automatic send_tx(input int gap);
      for (int i = 0; i < tx.size(); i++) begin
         strobe(tx[i]);
         if (i != tx.size() - 1) idle(gap);
      end
   endtask

   // Append a frame built from pay[]; flip != 0 corrupts the checksum
   task automatic build(input logic [7:0] lenb, input logic [7:0] cmd, input logic [7:0] flip);
      logic [7:0] x;
      x = lenb ^ cmd;
      tx.push_back(8'h55);
      tx.push_back(8'hAA);
      tx.push_back(lenb);
      tx.push_back(cmd);
      foreach (pay[i]) begin
         tx.push_back(pay[i]);
         x = x ^ pay[i];
      end
      tx.push_back(x ^ flip);
   endtask

   task automatic check_frame(input string tag, input logic [7:0] ecmd, input int nerr,
                              input logic [1:0] ecode, input int ecyc, input int pstart);
      check({tag, "_npld"}, q_pld.size(), exp_pld.size());
      for (int i = 0; i < exp_pld.size() && i < q_pld.size(); i++) begin
         check($sformatf("%s_data%0d", tag, i), q_pld[i], exp_pld[i]);
         check($sformatf("%s_last%0d", tag, i), q_last[i], (i == exp_pld.size() - 1));
         check($sformatf("%s_cyc%0d", tag, i), q_pcyc[i], pstart + i);
      end
      if (exp_pld.size() > 0 && q_cmd.size() > 0) check({tag, "_cmd_first"}, q_cmd[0], ecmd);
      check({tag, "_frame_ok"}, n_fok - fok_base, (exp_pld.size() > 0) ? 1 : 0);
      check({tag, "_nerr"}, q_err.size(), nerr);
      if (nerr > 0 && q_err.size() > 0) begin
         check({tag, "_ecode"}, q_err[0], ecode);
         check({tag, "_ecyc"}, q_ecyc[0], ecyc);
         check({tag, "_ecode_held"}, err_code, ecode);
      end
      check({tag, "_out_cmd"}, out_cmd, ecmd);
      check({tag, "_mon"}, mon_bad, 0);
      q_pld.delete(); q_last.delete(); q_pcyc.delete(); q_cmd.delete();
      q_err.delete(); q_ecyc.delete();
      exp_pld.delete();
      fok_base = n_fok;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_out_cmd"}, out_cmd, 0);
      check({tag, "_pld_data"}, pld_data, 0);
      check({tag, "_pld_valid"}, pld_valid, 0);
      check({tag, "_pld_last"}, pld_last, 0);
      check({tag, "_frame_ok"}, frame_ok, 0);
      check({tag, "_err_flag"}, err_flag, 0);
      check({tag, "_err_code"}, err_code, 0);
   endtask

   initial begin
      logic [7:0] cur_cmd;
      logic [7:0] cmd;
      logic [7:0] lenb;
      int         chk_s;
      int         len_s;
      int         kind;

      cur_cmd = 8'h00;

      // Reset state
      idle(3);
      check_zero("reset");
      sys_rst_n = 1'b1;
      idle(2);

      // Good frame 03 10 01 02 04
      tx.delete(); pay.delete();
      pay.push_back(8'h01); pay.push_back(8'h02); pay.push_back(8'h04);
      build(8'h03, 8'h10, 8'h00);
      send_tx(2); chk_s = last_s; idle(24);
      exp_pld = pay;
      cur_cmd = 8'h10;
      check_frame("good", cur_cmd, 0, 2'd0, 0, chk_s + 1);

      // Same frame, CHK forced to 0x17 (true checksum is 0x14)
      tx.delete();
      build(8'h03, 8'h10, 8'h14 ^ 8'h17);
      send_tx(2); chk_s = last_s; idle(24);
      check_frame("badchk", cur_cmd, 1, 2'd2, chk_s + 1, 0);

      // Resync on repeated HDR0
      tx.delete(); pay.delete();
      tx.push_back(8'h55);
      pay.push_back(8'h7F);
      build(8'h01, 8'h20, 8'h00);
      send_tx(2); chk_s = last_s; idle(24);
      exp_pld = pay;
      cur_cmd = 8'h20;
      check_frame("resync", cur_cmd, 0, 2'd0, 0, chk_s + 1);

      // Illegal lengths 0 and 17
      tx.delete(); tx.push_back(8'h55); tx.push_back(8'hAA); tx.push_back(8'h00);
      send_tx(2); idle(8);
      check_frame("len0", cur_cmd, 1, 2'd1, last_s + 1, 0);
      tx.delete(); tx.push_back(8'h55); tx.push_back(8'hAA); tx.push_back(8'h11);
      send_tx(2); idle(8);
      check_frame("len17", cur_cmd, 1, 2'd1, last_s + 1, 0);

      // Good frame after length errors
      tx.delete(); pay.delete();
      pay.push_back(8'hC3); pay.push_back(8'h3C);
      build(8'h02, 8'h42, 8'h00);
      send_tx(2); chk_s = last_s; idle(24);
      exp_pld = pay;
      cur_cmd = 8'h42;
      check_frame("after_len", cur_cmd, 0, 2'd0, 0, chk_s + 1);

      // Timeout after LEN: error T cycles after the LEN strobe edge
      tx.delete(); tx.push_back(8'h55); tx.push_back(8'hAA); tx.push_back(8'h02);
      send_tx(2); len_s = last_s; idle(T + 10);
      check_frame("tmo", cur_cmd, 1, 2'd3, len_s + T + 1, 0);

      // Strobe exactly in the expiry cycle: no timeout
      tx.delete(); tx.push_back(8'h55); tx.push_back(8'hAA); tx.push_back(8'h02);
      send_tx(2); idle(T - 1);
      tx.delete(); pay.delete();
      pay.push_back(8'hAB); pay.push_back(8'hCD);
      tx.push_back(8'h33); tx.push_back(8'hAB); tx.push_back(8'hCD);
      tx.push_back(8'h02 ^ 8'h33 ^ 8'hAB ^ 8'hCD);
      send_tx(2); chk_s = last_s; idle(24);
      exp_pld = pay;
      cur_cmd = 8'h33;
      check_frame("tmo_edge", cur_cmd, 0, 2'd0, 0, chk_s + 1);

      // Overrun during a 16-byte emission; dropped 0x55 must not start a frame
      tx.delete(); pay.delete();
      for (int i = 0; i < MAX_LEN; i++) pay.push_back(8'($urandom));
      build(8'(MAX_LEN), 8'h5A, 8'h00);
      send_tx(2); chk_s = last_s;
      idle(3); strobe(8'h55); len_s = last_s;
      idle(20);
      tx.delete();
      tx.push_back(8'hAA); tx.push_back(8'h01); tx.push_back(8'h20);
      tx.push_back(8'h7F); tx.push_back(8'h5E);
      send_tx(2); idle(24);
      exp_pld = pay;
      cur_cmd = 8'h5A;
      check_frame("overrun", cur_cmd, 1, 2'd0, len_s + 1, chk_s + 1);

      // Reset in the middle of the payload
      tx.delete();
      tx.push_back(8'h55); tx.push_back(8'hAA); tx.push_back(8'h04);
      tx.push_back(8'h30); tx.push_back(8'h11); tx.push_back(8'h22);
      send_tx(2); idle(1);
      sys_rst_n = 1'b0;
      #1;
      check_zero("midrst");
      idle(2);
      sys_rst_n = 1'b1;
      idle(2);
      cur_cmd = 8'h00;
      tx.delete(); pay.delete();
      pay.push_back(8'h99);
      build(8'h01, 8'h77, 8'h00);
      send_tx(2); chk_s = last_s; idle(24);
      exp_pld = pay;
      cur_cmd = 8'h77;
      check_frame("post_rst", cur_cmd, 0, 2'd0, 0, chk_s + 1);

      // Randomized frames: good, bad checksum, bad length, with idle garbage
      for (int f = 0; f < 24; f++) begin
         tx.delete(); pay.delete();
         for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
            logic [7:0] gb;
            gb = 8'($urandom);
            if (gb == 8'h55) gb = 8'h00;
            tx.push_back(gb);
         end
         kind = $urandom_range(0, 3);
         cmd  = 8'($urandom);
         if (kind == 3) begin
            lenb = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255));
            tx.push_back(8'h55); tx.push_back(8'hAA); tx.push_back(lenb);
            send_tx(2); idle(8);
            check_frame($sformatf("rnd%0d_len", f), cur_cmd, 1, 2'd1, last_s + 1, 0);
         end else begin
            int n;
            n = $urandom_range(1, MAX_LEN);
            for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
            if (kind == 2) begin
               build(8'(n), cmd, 8'($urandom_range(1, 255)));
               send_tx(2); chk_s = last_s; idle(24);
               check_frame($sformatf("rnd%0d_chk", f), cur_cmd, 1, 2'd2, chk_s + 1, 0);
            end else begin
               build(8'(n), cmd, 8'h00);
               send_tx(2); chk_s = last_s; idle(24);
               exp_pld = pay;
               cur_cmd = cmd;
               check_frame($sformatf("rnd%0d_ok", f), cur_cmd, 0, 2'd0, 0, chk_s + 1);
            end
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
